// File: rtl/systolic_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | systolic_pkg: shared widths, control bit indices, drain markers,  |
// | frame record and lane-slice helper for the systolic MAC PE.       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package systolic_pkg;

  localparam int DEF_ELEM_W = 4;
  localparam int DEF_LANES  = 4;
  localparam int DEF_ACC_W  = 16;

  localparam int FRAME_W    = DEF_ELEM_W * DEF_LANES;
  localparam int CTRL_W     = 4;
  localparam int LANE_IDX_W = $clog2(DEF_LANES);

  localparam int CTRL_DRAIN = 3;
  localparam int CTRL_CLEAR = 2;

  localparam logic [CTRL_W-1:0] DRAIN_MARK     = 4'b1000;
  localparam logic [CTRL_W-1:0] DRAIN_MARK_SAT = 4'b1100;

  typedef struct packed {
    logic [FRAME_W-1:0] col;
    logic [CTRL_W-1:0]  col_ctrl;
    logic [FRAME_W-1:0] row;
    logic [CTRL_W-1:0]  row_ctrl;
  } frame_t;

  // Lane 0 is the first nibble on the link, i.e. the most significant one.
  function automatic logic [DEF_ELEM_W-1:0] lane_slice(
    input logic [FRAME_W-1:0]    frame,
    input logic [LANE_IDX_W-1:0] idx
  );
    return frame[(DEF_LANES - 1 - int'(idx)) * DEF_ELEM_W +: DEF_ELEM_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_mac_pe_mac_lane.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mac_lane: masked signed ELEM_W x ELEM_W multiply followed by a    |
// | saturating ACC_W accumulate.                  Revision: 1.0       |
// +------------------------------------------------------------------+
module mac_lane #(
  parameter int ELEM_W = 4,
  parameter int ACC_W  = 16
) (
  input  logic [ELEM_W-1:0]       a_i,
  input  logic [ELEM_W-1:0]       b_i,
  input  logic                    en_i,
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [ACC_W-1:0] next_acc_o,
  output logic                    sat_o
);

  localparam int PROD_W = 2 * ELEM_W;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [PROD_W-1:0] w_a;
  logic signed [PROD_W-1:0] w_b;
  logic signed [PROD_W-1:0] w_prod;
  logic        [ACC_W:0]    w_sum;

  always_comb begin
    w_a    = {{ELEM_W{a_i[ELEM_W-1]}}, a_i};
    w_b    = {{ELEM_W{b_i[ELEM_W-1]}}, b_i};
    w_prod = en_i ? (w_a * w_b) : '0;
    // One guard bit is enough: overflow shows as the two top bits disagreeing.
    w_sum  = {acc_i[ACC_W-1], acc_i}
           + {{(ACC_W + 1 - PROD_W){w_prod[PROD_W-1]}}, w_prod};
    sat_o  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    if (sat_o) begin
      next_acc_o = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      next_acc_o = w_sum[ACC_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/systolic_mac_pe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | systolic_mac_pe: frame-at-a-time signed dot-product MAC, one lane |
// | per cycle, forwarding frames or draining the accumulator. Rev 1.0 |
// +------------------------------------------------------------------+
module systolic_mac_pe
  import systolic_pkg::*;
#(
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int LANES  = DEF_LANES,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [LANES*ELEM_W-1:0]   col_in,
  input  logic [LANES-1:0]          col_ctrl_in,
  input  logic [LANES*ELEM_W-1:0]   row_in,
  input  logic [CTRL_W-1:0]         row_ctrl_in,
  output logic                      out_valid,
  output logic [LANES*ELEM_W-1:0]   col_out,
  output logic [LANES-1:0]          col_ctrl_out,
  output logic [LANES*ELEM_W-1:0]   row_out,
  output logic [CTRL_W-1:0]         row_ctrl_out,
  output logic signed [ACC_W-1:0]   acc_q,
  output logic                      ovf_sticky,
  output logic                      err_sticky
);

  localparam int FW = LANES * ELEM_W;

  frame_t                  frame_q;
  logic                    active_q;
  logic [LANE_IDX_W-1:0]   lane_q;
  logic                    sat_q;
  logic signed [ACC_W-1:0] acc_d;

  logic                    w_last;
  logic                    w_busy;
  logic                    w_capture;
  logic                    w_drop;
  logic                    w_drain;
  logic                    w_mask;
  logic                    w_sat;
  logic                    w_frame_sat;
  logic [ELEM_W-1:0]       w_col_lane;
  logic [ELEM_W-1:0]       w_row_lane;
  logic signed [ACC_W-1:0] w_next_acc;

  mac_lane #(
    .ELEM_W (ELEM_W),
    .ACC_W  (ACC_W)
  ) u_mac_lane (
    .a_i        (w_col_lane),
    .b_i        (w_row_lane),
    .en_i       (w_mask),
    .acc_i      (acc_q),
    .next_acc_o (w_next_acc),
    .sat_o      (w_sat)
  );

  always_comb begin
    w_col_lane  = lane_slice(frame_q.col, lane_q);
    w_row_lane  = lane_slice(frame_q.row, lane_q);
    w_mask      = frame_q.col_ctrl[LANE_IDX_W'(LANES - 1) - lane_q];
    w_last      = active_q && (lane_q == LANE_IDX_W'(LANES - 1));
    // The last lane cycle accepts a new frame, giving a bubble-free cadence.
    w_busy      = active_q && !w_last;
    w_capture   = in_valid && !w_busy;
    w_drop      = in_valid && w_busy;
    w_drain     = frame_q.row_ctrl[CTRL_DRAIN];
    w_frame_sat = sat_q | w_sat;

    acc_d = acc_q;
    if (active_q) begin
      acc_d = w_next_acc;
    end
    if (w_last && w_drain) begin
      acc_d = '0;
    end
    if (w_capture && row_ctrl_in[CTRL_CLEAR]) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_q      <= '0;
      active_q     <= 1'b0;
      lane_q       <= '0;
      sat_q        <= 1'b0;
      acc_q        <= '0;
      ovf_sticky   <= 1'b0;
      err_sticky   <= 1'b0;
      out_valid    <= 1'b0;
      col_out      <= '0;
      col_ctrl_out <= '0;
      row_out      <= '0;
      row_ctrl_out <= '0;
    end else begin
      acc_q      <= acc_d;
      ovf_sticky <= ovf_sticky | (active_q & w_sat);
      err_sticky <= err_sticky | w_drop;
      out_valid  <= w_last;

      if (w_capture) begin
        sat_q <= 1'b0;
      end else if (active_q && w_sat) begin
        sat_q <= 1'b1;
      end

      if (w_capture) begin
        active_q <= 1'b1;
        lane_q   <= '0;
      end else if (w_last) begin
        active_q <= 1'b0;
        lane_q   <= '0;
      end else if (active_q) begin
        lane_q   <= lane_q + LANE_IDX_W'(1);
      end

      if (w_last) begin
        col_out      <= frame_q.col;
        col_ctrl_out <= frame_q.col_ctrl;
        if (w_drain) begin
          row_out      <= FW'(w_next_acc);
          row_ctrl_out <= w_frame_sat ? DRAIN_MARK_SAT : DRAIN_MARK;
        end else begin
          row_out      <= frame_q.row;
          row_ctrl_out <= frame_q.row_ctrl;
        end
      end

      if (w_capture) begin
        frame_q.col      <= col_in;
        frame_q.col_ctrl <= col_ctrl_in;
        frame_q.row      <= row_in;
        frame_q.row_ctrl <= row_ctrl_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_mac_pe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_systolic_mac_pe: randomized and directed frames checked against|
// | a frame-level dot-product reference model.        Revision: 1.0   |
// +------------------------------------------------------------------+
module tb_systolic_mac_pe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] col_in = '0;
  logic [3:0]  col_ctrl_in = '0;
  logic [15:0] row_in = '0;
  logic [3:0]  row_ctrl_in = '0;
  logic        out_valid;
  logic [15:0] col_out;
  logic [3:0]  col_ctrl_out;
  logic [15:0] row_out;
  logic [3:0]  row_ctrl_out;
  logic signed [15:0] acc_q;
  logic        ovf_sticky;
  logic        err_sticky;

  systolic_mac_pe dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .col_in       (col_in),
    .col_ctrl_in  (col_ctrl_in),
    .row_in       (row_in),
    .row_ctrl_in  (row_ctrl_in),
    .out_valid    (out_valid),
    .col_out      (col_out),
    .col_ctrl_out (col_ctrl_out),
    .row_out      (row_out),
    .row_ctrl_out (row_ctrl_out),
    .acc_q        (acc_q),
    .ovf_sticky   (ovf_sticky),
    .err_sticky   (err_sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [15:0] col;
    logic [3:0]  cc;
    logic [15:0] row;
    logic [3:0]  rc;
  } exp_t;

  exp_t exp_q[$];
  int   m_acc = 0;
  bit   m_ovf = 0;
  bit   m_err = 0;
  bit   m_have = 0;
  int   m_last = 0;

  // Whole-frame reference: dot product with a clamp after every lane sum.
  task automatic model_send(input logic [15:0] c, input logic [3:0] cm,
                            input logic [15:0] r, input logic [3:0] rc);
    exp_t e;
    int   s;
    bit   fsat;
    logic signed [3:0] a;
    logic signed [3:0] b;
    if (m_have && (cyc < m_last + 4)) begin
      m_err = 1;
      return;
    end
    m_have = 1;
    m_last = cyc;
    fsat   = 0;
    if (rc[2]) m_acc = 0;
    for (int i = 0; i < 4; i++) begin
      a = c[15-4*i -: 4];
      b = r[15-4*i -: 4];
      s = m_acc + (cm[3-i] ? int'(a) * int'(b) : 0);
      if (s > 32767) begin
        s = 32767;
        fsat = 1;
      end else if (s < -32768) begin
        s = -32768;
        fsat = 1;
      end
      m_acc = s;
    end
    if (fsat) m_ovf = 1;
    e.cyc = cyc + 5;
    e.col = c;
    e.cc  = cm;
    if (rc[3]) begin
      e.row = 16'(m_acc);
      e.rc  = fsat ? 4'b1100 : 4'b1000;
      m_acc = 0;
    end else begin
      e.row = r;
      e.rc  = rc;
    end
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [15:0] c, input logic [3:0] cm,
                      input logic [15:0] r, input logic [3:0] rc);
    @(negedge clk);
    in_valid    = 1'b1;
    col_in      = c;
    col_ctrl_in = cm;
    row_in      = r;
    row_ctrl_in = rc;
    model_send(c, cm, r, rc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    m_acc  = 0;
    m_ovf  = 0;
    m_err  = 0;
    m_have = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_acc"}, {16'h0, acc_q}, {16'h0, 16'(m_acc)});
    chk({tag, "_ovf"}, {31'h0, ovf_sticky}, {31'h0, m_ovf});
    chk({tag, "_err"}, {31'h0, err_sticky}, {31'h0, m_err});
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("out_valid_missing", 32'h0, 32'h1);
        void'(exp_q.pop_front());
      end
      if (out_valid || (exp_q.size() > 0 && exp_q[0].cyc == cyc)) begin
        chk("out_valid", {31'h0, out_valid},
            {31'h0, (exp_q.size() > 0 && exp_q[0].cyc == cyc)});
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          chk("col_out",      {16'h0, col_out},      {16'h0, exp_q[0].col});
          chk("col_ctrl_out", {28'h0, col_ctrl_out}, {28'h0, exp_q[0].cc});
          chk("row_out",      {16'h0, row_out},      {16'h0, exp_q[0].row});
          chk("row_ctrl_out", {28'h0, row_ctrl_out}, {28'h0, exp_q[0].rc});
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rc_v;
    logic [15:0] cv;
    logic [15:0] rv;

    do_reset();
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_col_out",   {16'h0, col_out},   32'h0);
    chk("rst_row_out",   {16'h0, row_out},   32'h0);
    chk("rst_col_ctrl",  {28'h0, col_ctrl_out}, 32'h0);
    chk("rst_row_ctrl",  {28'h0, row_ctrl_out}, 32'h0);
    chk("rst_acc",       {16'h0, acc_q},     32'h0);
    chk("rst_ovf",       {31'h0, ovf_sticky}, 32'h0);
    chk("rst_err",       {31'h0, err_sticky}, 32'h0);

    send(16'h1234, 4'hF, 16'h1111, 4'b0000);
    idle(8);
    chk("basic_acc", {16'h0, acc_q}, 32'd10);
    check_state("basic");

    send(16'h8888, 4'hF, 16'h8888, 4'b0100);
    idle(3);
    send(16'h8888, 4'hF, 16'h8888, 4'b1000);
    idle(8);
    chk("drain_acc_zero", {16'h0, acc_q}, 32'd0);

    send(16'h7777, 4'b1010, 16'h7777, 4'b1000);
    idle(8);
    check_state("mask");

    for (int i = 0; i < 128; i++) begin
      send(16'h8888, 4'hF, 16'h8888, 4'b0000);
      idle(3);
    end
    send(16'h8888, 4'hF, 16'h8888, 4'b1000);
    idle(8);
    chk("sat_ovf", {31'h0, ovf_sticky}, 32'h1);
    check_state("sat");

    do_reset();
    send(16'h1234, 4'hF, 16'h4321, 4'b0000);
    idle(1);
    send(16'hFFFF, 4'hF, 16'hFFFF, 4'b0100);
    idle(8);
    chk("collide_err", {31'h0, err_sticky}, 32'h1);
    check_state("collide");

    do_reset();
    send(16'h1234, 4'hF, 16'h4321, 4'b0000);
    idle(3);
    send(16'h2222, 4'hF, 16'h3333, 4'b0010);
    idle(8);
    check_state("cadence");

    send(16'h7777, 4'hF, 16'h7777, 4'b0000);
    idle(1);
    do_reset();
    idle(8);
    check_state("midreset");

    send(16'h5500, 4'hF, 16'h5500, 4'b0000);
    idle(8);
    chk("acc50", {16'h0, acc_q}, 32'd50);
    send(16'h7000, 4'hF, 16'h1000, 4'b1110);
    idle(8);
    check_state("drain_clear");

    do_reset();
    for (int i = 0; i < 300; i++) begin
      idle($urandom_range(0, 5));
      rc_v = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       begin cv = 16'h8888; rv = 16'h8888; end
        1:       begin cv = 16'h7777; rv = 16'h8888; end
        default: begin cv = 16'($urandom); rv = 16'($urandom); end
      endcase
      send(cv, 4'($urandom), rv, rc_v[3:0]);
    end
    idle(10);
    check_state("random");
    chk("queue_empty", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
